occupancy_grid_controller: RTL and testbench

Sequences the single-port 256x128 occupancy-grid RAM for the SLAM pipeline. Three clients share it through one FSM: scan-update requests, which do a saturating read-modify-write of one cell; map queries, which read one cell; and a full-map clear sweep. It sits between the scan-matcher/map-update logic and the grid RAM, and is the RAM's only driver.

---
 rtl/occupancy_grid_pkg.sv | 28 ++
 rtl/cell_saturating_update.sv | 31 +++
 rtl/occupancy_grid_controller.sv | 144 ++++++++++++++
 tb/tb_occupancy_grid_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/occupancy_grid_pkg.sv
// Shared constants, FSM state encoding and address packing for the
// occupancy-grid RAM controller.
package occupancy_grid_pkg;

  localparam int GRID_WIDTH  = 256;
  localparam int GRID_HEIGHT = 128;
  localparam int ADDR_WIDTH  = 15;
  localparam int CELL_WIDTH  = 8;
  localparam int X_WIDTH     = $clog2(GRID_WIDTH);
  localparam int Y_WIDTH     = $clog2(GRID_HEIGHT);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RSP,
    CLR
  } state_t;

  // Row-major packing: row in the high bits, column in the low bits.
  function automatic logic [ADDR_WIDTH-1:0] cell_address(
    input logic [X_WIDTH-1:0] x,
    input logic [Y_WIDTH-1:0] y
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/cell_saturating_update.sv
// Combinational saturating hit/miss arithmetic for one grid cell.
module cell_saturating_update
  import occupancy_grid_pkg::*;
#(
  parameter logic [CELL_WIDTH-1:0] HIT_INC  = 8'd6,
  parameter logic [CELL_WIDTH-1:0] MISS_DEC = 8'd2,
  parameter logic [CELL_WIDTH-1:0] CELL_MIN = 8'd0,
  parameter logic [CELL_WIDTH-1:0] CELL_MAX = 8'd255
) (
  input  logic [CELL_WIDTH-1:0] old_value,
  input  logic                  hit,
  output logic [CELL_WIDTH-1:0] new_value
);

  // One extra bit of headroom so neither direction can wrap.
  logic [CELL_WIDTH:0] sum;
  logic [CELL_WIDTH:0] floor;

  assign sum   = {1'b0, old_value} + {1'b0, HIT_INC};
  assign floor = {1'b0, CELL_MIN} + {1'b0, MISS_DEC};

  always_comb begin
    new_value = old_value;
    if (hit) begin
      new_value = (sum > {1'b0, CELL_MAX}) ? CELL_MAX : sum[CELL_WIDTH-1:0];
    end else begin
      new_value = ({1'b0, old_value} < floor) ? CELL_MIN : old_value - MISS_DEC;
    end
  end

endmodule

// File: rtl/occupancy_grid_controller.sv
// Single-port grid RAM sequencer: arbitrated update RMW, query read and
// full-map clear sweep sharing one FSM.
module occupancy_grid_controller
  import occupancy_grid_pkg::*;
#(
  parameter logic [CELL_WIDTH-1:0] HIT_INC     = 8'd6,
  parameter logic [CELL_WIDTH-1:0] MISS_DEC    = 8'd2,
  parameter logic [CELL_WIDTH-1:0] CELL_MIN    = 8'd0,
  parameter logic [CELL_WIDTH-1:0] CELL_MAX    = 8'd255,
  parameter logic [CELL_WIDTH-1:0] CLEAR_VALUE = 8'd128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [X_WIDTH-1:0]    upd_x,
  input  logic [Y_WIDTH-1:0]    upd_y,
  input  logic                  upd_hit,
  input  logic                  qry_valid,
  output logic                  qry_ready,
  input  logic [X_WIDTH-1:0]    qry_x,
  input  logic [Y_WIDTH-1:0]    qry_y,
  output logic                  rsp_valid,
  output logic [CELL_WIDTH-1:0] rsp_data,
  input  logic                  clear_start,
  output logic                  clearing,
  output logic                  clear_done,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [CELL_WIDTH-1:0] ram_input_data,
  input  logic [CELL_WIDTH-1:0] ram_output_data
);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    op_upd_reg;
  logic                    hit_reg;
  logic                    prefer_upd_reg;
  logic                    clear_pending_reg;
  logic                    clear_done_reg;
  logic [ADDR_WIDTH-1:0]   clr_cnt_reg;
  logic [CELL_WIDTH-1:0]   rsp_hold_reg;
  logic [CELL_WIDTH-1:0]   new_value;
  logic                    idle_open;
  logic                    sweep_last;

  cell_saturating_update #(
    .HIT_INC  (HIT_INC),
    .MISS_DEC (MISS_DEC),
    .CELL_MIN (CELL_MIN),
    .CELL_MAX (CELL_MAX)
  ) u_sat (
    .old_value (ram_output_data),
    .hit       (hit_reg),
    .new_value (new_value)
  );

  assign idle_open  = (state_reg == IDLE) && !clear_pending_reg;
  assign upd_ready  = idle_open && upd_valid && (!qry_valid || prefer_upd_reg);
  assign qry_ready  = idle_open && qry_valid && !upd_ready;
  assign sweep_last = (state_reg == CLR) && (&clr_cnt_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (clear_pending_reg) begin
          state_next = CLR;
        end else if (upd_ready || qry_ready) begin
          state_next = RD;
        end
      end
      RD:      state_next = op_upd_reg ? WR : RSP;
      WR:      state_next = IDLE;
      RSP:     state_next = IDLE;
      CLR:     state_next = sweep_last ? IDLE : CLR;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_write_enable = 1'b0;
    ram_address      = '0;
    ram_input_data   = '0;
    case (state_reg)
      RD, RSP: ram_address = addr_reg;
      WR: begin
        ram_write_enable = 1'b1;
        ram_address      = addr_reg;
        ram_input_data   = new_value;
      end
      CLR: begin
        ram_write_enable = 1'b1;
        ram_address      = clr_cnt_reg;
        ram_input_data   = CLEAR_VALUE;
      end
      default: ;
    endcase
  end

  // Response data passes straight through in RSP and is held afterwards.
  assign rsp_valid  = (state_reg == RSP);
  assign rsp_data   = rsp_valid ? ram_output_data : rsp_hold_reg;
  assign clearing   = clear_pending_reg;
  assign clear_done = clear_done_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      op_upd_reg        <= 1'b0;
      hit_reg           <= 1'b0;
      prefer_upd_reg    <= 1'b1;
      clear_pending_reg <= 1'b0;
      clear_done_reg    <= 1'b0;
      clr_cnt_reg       <= '0;
      rsp_hold_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      clear_done_reg <= sweep_last;
      if (upd_ready) begin
        addr_reg       <= cell_address(upd_x, upd_y);
        op_upd_reg     <= 1'b1;
        hit_reg        <= upd_hit;
        prefer_upd_reg <= 1'b0;
      end else if (qry_ready) begin
        addr_reg       <= cell_address(qry_x, qry_y);
        op_upd_reg     <= 1'b0;
        prefer_upd_reg <= 1'b1;
      end
      // Counter wraps to zero on the last sweep write, ready for the next clear.
      clr_cnt_reg <= (state_reg == CLR) ? clr_cnt_reg + 1'b1 : '0;
      if (sweep_last) begin
        clear_pending_reg <= 1'b0;
      end else if (clear_start) begin
        clear_pending_reg <= 1'b1;
      end
      if (state_reg == RSP) begin
        rsp_hold_reg <= ram_output_data;
      end
    end
  end

endmodule

// File: tb/tb_occupancy_grid_controller.sv
// Scoreboard bench: stimulus pushes expected RAM writes / responses, a
// negedge monitor pops and compares them against what the controller emits.
module tb_occupancy_grid_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        upd_valid, upd_ready, upd_hit;
  logic [7:0]  upd_x;
  logic [6:0]  upd_y;
  logic        qry_valid, qry_ready;
  logic [7:0]  qry_x;
  logic [6:0]  qry_y;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        clear_start, clearing, clear_done;
  logic        ram_write_enable;
  logic [14:0] ram_address;
  logic [7:0]  ram_input_data;
  logic [7:0]  ram_output_data;

  logic [7:0]  mem [0:32767];
  logic        pre_we = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  typedef struct {
    bit          is_rsp;
    logic [14:0] addr;
    logic [7:0]  data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   expect_sweep = 1'b0;
  int   sweep_cnt = 0;
  int   sweep_bad = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Single-port RAM with registered read, plus a bench-only preload port.
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_write_enable) mem[ram_address] <= ram_input_data;
    ram_output_data <= mem[ram_address];
  end

  occupancy_grid_controller dut (
    .clock            (clock),
    .reset            (reset),
    .upd_valid        (upd_valid),
    .upd_ready        (upd_ready),
    .upd_x            (upd_x),
    .upd_y            (upd_y),
    .upd_hit          (upd_hit),
    .qry_valid        (qry_valid),
    .qry_ready        (qry_ready),
    .qry_x            (qry_x),
    .qry_y            (qry_y),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .clear_start      (clear_start),
    .clearing         (clearing),
    .clear_done       (clear_done),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_input_data   (ram_input_data),
    .ram_output_data  (ram_output_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (ram_write_enable === 1'b1) begin
      if (sbq.size() > 0 && !sbq[0].is_rsp) begin
        mon_e = sbq.pop_front();
        check({mon_e.name, "_waddr"}, 32'(ram_address), 32'(mon_e.addr));
        check({mon_e.name, "_wdata"}, 32'(ram_input_data), 32'(mon_e.data));
        check({mon_e.name, "_wcycle"}, cyc, mon_e.cyc);
      end else if (expect_sweep) begin
        if (ram_address !== sweep_cnt[14:0] || ram_input_data !== 8'd128) sweep_bad++;
        sweep_cnt++;
      end else begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write actual=addr %0h data %0d required=no write", ram_address, ram_input_data);
      end
    end
    if (rsp_valid === 1'b1) begin
      if (sbq.size() > 0 && sbq[0].is_rsp) begin
        mon_e = sbq.pop_front();
        check({mon_e.name, "_rdata"}, 32'(rsp_data), 32'(mon_e.data));
        check({mon_e.name, "_rcycle"}, cyc, mon_e.cyc);
      end else begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp actual=%0d required=no response", rsp_data);
      end
    end
    if (clear_done === 1'b1) begin
      check("sweep_writes", sweep_cnt, 32768);
      check("sweep_bad_writes", sweep_bad, 0);
      sweep_cnt = 0;
      sweep_bad = 0;
    end
  end

  task automatic preload(input logic [14:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_grant(input bit is_upd, input string name, output int acc);
    int n = 0;
    #1;
    while (!(is_upd ? upd_ready : qry_ready) && n < 50) begin
      @(negedge clock); #1; n++;
    end
    check({name, "_granted"}, 32'(is_upd ? upd_ready : qry_ready), 1);
    acc = cyc;
  endtask

  task automatic do_update(input logic [7:0] x, input logic [6:0] y, input bit hit,
                           input logic [7:0] expv, input string name);
    int acc;
    upd_x = x; upd_y = y; upd_hit = hit; upd_valid = 1'b1;
    wait_grant(1'b1, name, acc);
    sbq.push_back('{1'b0, {y, x}, expv, acc + 2, name});
    @(negedge clock);
    check({name, "_rdy_c1"}, 32'(upd_ready), 0);
    @(negedge clock);
    check({name, "_rdy_c2"}, 32'(upd_ready), 0);
    upd_valid = 1'b0;
  endtask

  task automatic do_query(input logic [7:0] x, input logic [6:0] y,
                          input logic [7:0] expv, input string name);
    int acc;
    qry_x = x; qry_y = y; qry_valid = 1'b1;
    wait_grant(1'b0, name, acc);
    sbq.push_back('{1'b1, 15'd0, expv, acc + 2, name});
    @(negedge clock);
    check({name, "_rdy_c1"}, 32'(qry_ready), 0);
    @(negedge clock);
    qry_valid = 1'b0;
    @(negedge clock);
    check({name, "_pulse_end"}, 32'(rsp_valid), 0);
    check({name, "_hold"}, 32'(rsp_data), 32'(expv));
  endtask

  initial begin
    int acc, n, g, last;
    bit bad;
    reset = 1'b1;
    upd_valid = 0; upd_x = 0; upd_y = 0; upd_hit = 0;
    qry_valid = 0; qry_x = 0; qry_y = 0; clear_start = 0;
    repeat (3) @(negedge clock);
    check("rst_we", 32'(ram_write_enable), 0);
    check("rst_addr", 32'(ram_address), 0);
    check("rst_din", 32'(ram_input_data), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_clearing", 32'(clearing), 0);
    check("rst_clear_done", 32'(clear_done), 0);
    check("rst_upd_ready", 32'(upd_ready), 0);
    reset = 1'b0;
    @(negedge clock);

    // Single updates and saturation boundaries.
    preload(15'h0203, 8'd128);  do_update(8'd3, 7'd2, 1'b1, 8'd134, "upd_hit_128");
    preload(15'h0707, 8'd252);  do_update(8'd7, 7'd7, 1'b1, 8'd255, "upd_hit_252");
    preload(15'h0909, 8'd1);    do_update(8'd9, 7'd9, 1'b0, 8'd0, "upd_miss_1");
    preload(15'h0A0A, 8'd128);  do_update(8'd10, 7'd10, 1'b0, 8'd126, "upd_miss_128");
    preload(15'h0B0B, 8'd250);  do_update(8'd11, 7'd11, 1'b1, 8'd255, "upd_hit_250");
    preload(15'h0C0C, 8'd2);    do_update(8'd12, 7'd12, 1'b0, 8'd0, "upd_miss_2");

    // Update then query of the same cell sees the written value.
    preload(15'h050A, 8'd128);
    do_update(8'd10, 7'd5, 1'b1, 8'd134, "rw_upd");
    do_query(8'd10, 7'd5, 8'd134, "rw_qry");

    // Round-robin with both requesters held valid.
    pulse_reset();
    preload(15'h0114, 8'd100);
    preload(15'h0115, 8'd77);
    upd_x = 8'd20; upd_y = 7'd1; upd_hit = 1'b1; qry_x = 8'd21; qry_y = 7'd1;
    upd_valid = 1'b1; qry_valid = 1'b1;
    g = 0; n = 0; last = 0;
    while (g < 4 && n < 60) begin
      #1;
      if (upd_ready && qry_ready) check("arb_exclusive", 32'(qry_ready), 0);
      if (upd_ready || qry_ready) begin
        check("arb_kind_is_upd", 32'(upd_ready), 32'((g % 2) == 0));
        if (g > 0) check("arb_spacing", cyc - last, 3);
        last = cyc;
        if (upd_ready) sbq.push_back('{1'b0, 15'h0114, (g == 0) ? 8'd106 : 8'd112, cyc + 2, "arb_upd"});
        else           sbq.push_back('{1'b1, 15'd0, 8'd77, cyc + 2, "arb_qry"});
        g++;
      end
      @(negedge clock);
      n++;
    end
    upd_valid = 1'b0; qry_valid = 1'b0;
    check("arb_grants", g, 4);
    repeat (3) @(negedge clock);

    // Reset in the middle of a write abandons it.
    preload(15'h0428, 8'd200);
    upd_x = 8'd40; upd_y = 7'd4; upd_hit = 1'b1; upd_valid = 1'b1;
    wait_grant(1'b1, "rstwr", acc);
    @(negedge clock);
    #7;
    check("rstwr_in_wr", 32'(ram_write_enable), 1);
    reset = 1'b1; upd_valid = 1'b0;
    #1;
    check("rstwr_we_drop", 32'(ram_write_enable), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rstwr_cell_kept", 32'(mem[15'h0428]), 200);
    upd_valid = 1'b1;
    #1;
    check("rstwr_ready_back", 32'(upd_ready), 1);
    upd_valid = 1'b0;
    do_query(8'd40, 7'd4, 8'd200, "rstwr_qry");

    // Clear requested during the read phase of an update.
    preload(15'h031E, 8'd50);
    upd_x = 8'd30; upd_y = 7'd3; upd_hit = 1'b1; upd_valid = 1'b1;
    wait_grant(1'b1, "clr_upd", acc);
    sbq.push_back('{1'b0, 15'h031E, 8'd56, acc + 2, "clr_upd"});
    @(negedge clock);
    upd_valid = 1'b0; clear_start = 1'b1; expect_sweep = 1'b1;
    qry_x = 8'd3; qry_y = 7'd2; qry_valid = 1'b1;
    @(negedge clock);
    clear_start = 1'b0;
    check("clr_clearing", 32'(clearing), 1);
    n = 0; bad = 0;
    while (clear_done !== 1'b1 && n < 33000) begin
      @(negedge clock);
      if (clear_done !== 1'b1 && qry_ready) bad = 1;
      n++;
    end
    check("clr_done_seen", 32'(clear_done), 1);
    check("clr_qry_blocked", 32'(bad), 0);
    check("clr_clearing_drop", 32'(clearing), 0);
    #1;
    check("clr_qry_granted", 32'(qry_ready), 1);
    sbq.push_back('{1'b1, 15'd0, 8'd128, cyc + 2, "clr_qry_0203"});
    @(negedge clock);
    check("clr_done_pulse", 32'(clear_done), 0);
    @(negedge clock);
    qry_valid = 1'b0;
    expect_sweep = 1'b0;
    @(negedge clock);
    do_query(8'd30, 7'd3, 8'd128, "clr_qry_031e");

    n = 0;
    while (sbq.size() > 0 && n < 20) begin
      @(negedge clock); n++;
    end
    check("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
